// File: rtl/lfsr_voice_scheduler_pkg.sv
// Shared types, constants and pitch table for the LFSR voice scheduler.
// Keys 0..7 map to C4..C5; periods are in clock cycles before DIV_SHIFT scaling.
package lfsr_voice_pkg;

    localparam int unsigned NUM_VOICES    = 3;
    localparam int unsigned NUM_KEYS_MAX  = 8;

    typedef logic [2:0] key_idx_t;
    typedef logic [1:0] rank_t;
    typedef logic [1:0] voice_idx_t;

    localparam rank_t RANK_NEWEST = 2'd0;
    localparam rank_t RANK_OLDEST = 2'd2;

    function automatic int unsigned base_period(input key_idx_t key);
        int unsigned p;
        case (key)
            3'd0:    p = 191;
            3'd1:    p = 170;
            3'd2:    p = 152;
            3'd3:    p = 143;
            3'd4:    p = 128;
            3'd5:    p = 114;
            3'd6:    p = 101;
            default: p = 96;
        endcase
        return p;
    endfunction

    function automatic int unsigned max_base_period();
        int unsigned m;
        m = 0;
        for (int k = 0; k < NUM_KEYS_MAX; k++) begin
            if (base_period(key_idx_t'(k)) > m) m = base_period(key_idx_t'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_voice_scheduler_if.sv
// Key-event and voice-status bundle between the key conditioners, the scheduler
// and the LFSR voices.
interface lfsr_voice_if #(
    parameter int unsigned NUM_KEYS = 8
);
    import lfsr_voice_pkg::*;

    logic [NUM_KEYS-1:0]     key_press;
    logic [NUM_KEYS-1:0]     key_release;
    logic [NUM_VOICES-1:0]   lfsr_en;
    logic [NUM_VOICES-1:0]   voice_active;
    logic [3*NUM_VOICES-1:0] voice_key;
    logic                    steal;

    modport master (
        output key_press,
        output key_release,
        input  lfsr_en,
        input  voice_active,
        input  voice_key,
        input  steal
    );

    modport slave (
        input  key_press,
        input  key_release,
        output lfsr_en,
        output voice_active,
        output voice_key,
        output steal
    );

endinterface

// File: rtl/lfsr_voice_scheduler_voice_divider.sv
// Per-voice pitch divider: counts 0..period-1 while active and emits a registered
// one-cycle strobe each time the count wraps.
module voice_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             restart,
    input  logic             clear,
    input  logic [DIV_W-1:0] period,
    output logic             strobe
);

    logic [DIV_W-1:0] count_q, count_d;
    logic             strobe_q, strobe_d;

    always_comb begin
        count_d  = count_q;
        strobe_d = 1'b0;
        if (restart || clear || !active) begin
            count_d = '0;
        end else if (count_q == period - DIV_W'(1)) begin
            count_d  = '0;
            strobe_d = 1'b1;
        end else begin
            count_d = count_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/lfsr_voice_scheduler.sv
// Polyphonic key-to-voice allocator: queues key events, services one per cycle,
// steals the oldest voice when full and paces each voice's LFSR at its pitch.
module lfsr_voice_scheduler
    import lfsr_voice_pkg::*;
#(
    parameter int unsigned NUM_KEYS  = 8,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_SHIFT = 8
) (
    input logic         clk,
    input logic         reset,
    lfsr_voice_if.slave bus
);

    localparam longint unsigned MaxPeriod = longint'(max_base_period()) << DIV_SHIFT;

    if (MaxPeriod >= (64'd1 << DIV_W)) begin : g_div_w_too_narrow
        $error("DIV_W cannot hold the longest scaled pitch period");
    end

    logic [NUM_KEYS-1:0] press_pend_q, press_pend_d;
    logic [NUM_KEYS-1:0] rel_pend_q, rel_pend_d;
    logic [NUM_KEYS-1:0] eff_press, eff_rel;
    logic [NUM_KEYS-1:0] press_clr, rel_clr;

    logic [NUM_VOICES-1:0]            active_q, active_d;
    key_idx_t [NUM_VOICES-1:0]        key_q, key_d;
    rank_t [NUM_VOICES-1:0]           rank_q, rank_d;
    logic                             steal_q, steal_d;
    logic [NUM_VOICES-1:0]            restart, clear, strobe;

    key_idx_t   rel_sel, press_sel;
    logic       rel_valid, press_valid, press_held, have_free;
    voice_idx_t free_sel, old_sel, tgt;

    // Pulses arriving this cycle are serviceable immediately, giving one-cycle latency.
    always_comb begin
        eff_press   = press_pend_q | bus.key_press;
        eff_rel     = rel_pend_q | bus.key_release;
        rel_valid   = |eff_rel;
        press_valid = |eff_press;
        rel_sel     = '0;
        press_sel   = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (eff_rel[k])   rel_sel   = key_idx_t'(k);
            if (eff_press[k]) press_sel = key_idx_t'(k);
        end
    end

    always_comb begin
        have_free  = 1'b0;
        free_sel   = '0;
        old_sel    = '0;
        press_held = 1'b0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active_q[v]) begin
                have_free = 1'b1;
                free_sel  = voice_idx_t'(v);
            end
            if (active_q[v] && rank_q[v] == RANK_OLDEST) old_sel = voice_idx_t'(v);
            if (active_q[v] && key_q[v] == press_sel)    press_held = 1'b1;
        end
        tgt = have_free ? free_sel : old_sel;
    end

    always_comb begin
        active_d  = active_q;
        key_d     = key_q;
        rank_d    = rank_q;
        steal_d   = 1'b0;
        restart   = '0;
        clear     = '0;
        press_clr = '0;
        rel_clr   = '0;
        if (rel_valid) begin
            rel_clr[rel_sel] = 1'b1;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && key_q[v] == rel_sel) begin
                    active_d[v] = 1'b0;
                    clear[v]    = 1'b1;
                end
            end
        end else if (press_valid) begin
            press_clr[press_sel] = 1'b1;
            if (!press_held) begin
                steal_d = !have_free;
                // Age every younger voice; a free target ages every other active voice.
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (voice_idx_t'(v) != tgt && active_q[v] && rank_q[v] != RANK_OLDEST &&
                        (!active_q[tgt] || rank_q[v] < rank_q[tgt])) begin
                        rank_d[v] = rank_q[v] + rank_t'(1);
                    end
                end
                active_d[tgt] = 1'b1;
                key_d[tgt]    = press_sel;
                rank_d[tgt]   = RANK_NEWEST;
                restart[tgt]  = 1'b1;
            end
        end
        // A fresh pulse on a bit being retired from the queue keeps it queued.
        press_pend_d = (eff_press & ~press_clr) | (bus.key_press & press_pend_q & press_clr);
        rel_pend_d   = (eff_rel & ~rel_clr) | (bus.key_release & rel_pend_q & rel_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            press_pend_q <= '0;
            rel_pend_q   <= '0;
            active_q     <= '0;
            key_q        <= '0;
            rank_q       <= '0;
            steal_q      <= 1'b0;
        end else begin
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            active_q     <= active_d;
            key_q        <= key_d;
            rank_q       <= rank_d;
            steal_q      <= steal_d;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [DIV_W-1:0] period;
        assign period = DIV_W'(base_period(key_q[v]) << DIV_SHIFT);

        voice_divider #(
            .DIV_W (DIV_W)
        ) u_divider (
            .clk     (clk),
            .reset   (reset),
            .active  (active_q[v]),
            .restart (restart[v]),
            .clear   (clear[v]),
            .period  (period),
            .strobe  (strobe[v])
        );
    end

    assign bus.lfsr_en      = strobe;
    assign bus.voice_active = active_q;
    assign bus.voice_key    = key_q;
    assign bus.steal        = steal_q;

endmodule

// File: doc/lfsr_voice_scheduler.md
Name: lfsr_voice_scheduler

Overview:
- Allocates up to 8 piano keys onto the 3 LFSR tone voices and paces each voice's LFSR enable at its note's pitch period.
- Sits between the per-key input conditioners and the three LFSR instances.
- Replaces the static key-to-enable LUT with polyphonic allocation, oldest-voice stealing and per-voice pitch dividers.

Parameters:
- NUM_KEYS, 8, number of key inputs. Fixed at 8; the key index is 3 bits.
- DIV_W, 16, width of each voice divider counter.
- DIV_SHIFT, 8, left shift applied to the base period table. The bench uses 0.

Ports:
- clk  in  1  system clock; the block uses this single clock only.
- reset  in  1  synchronous, active-high reset.
- key_press  in  8  one-cycle rising-edge pulses per key, from the conditioners.
- key_release  in  8  one-cycle falling-edge pulses per key.
- lfsr_en  out  3  one-cycle step strobe per voice, driving the LFSR enable.
- voice_active  out  3  voice currently holds a key.
- voice_key  out  9  3-bit key index per voice; voice v occupies bits [3v+2:3v].
- steal  out  1  one-cycle pulse when an active voice is reassigned.

Behaviour:
- Reset: the following all clear at the next clk edge while reset is high:
  - lfsr_en, voice_active, voice_key, steal = 0
  - pending bitmaps, dividers and age ranks = 0
  - Reset mid-operation discards all pending events and silences all voices.
- Event capture:
  - press_pend |= key_press and rel_pend |= key_release every cycle.
  - When a bit is cleared by processing and a new pulse for the same bit arrives in the same cycle, the new pulse wins and the bit stays set.
- Event service, one event per cycle. Releases have priority over presses; within a class, the lowest key index goes first.
  - Release k: if a voice holds k, clear its voice_active and divider. Age ranks of the other voices are unchanged. If no voice holds k, the event is dropped.
  - Press k when k is already held: dropped, no restart.
  - Press k when a free voice exists: allocate the lowest-index free voice.
  - Press k when all voices are busy: steal the active voice with rank 2 and pulse steal in the cycle the new key is written.
  - Latency: an event pulse at cycle t updates voice_active/voice_key at t+1 when uncontended. Queued events add one cycle each.
  - A press and release of the same key in the same cycle: the release is serviced first, then the press, so the key ends allocated.
- Age ranks (2 bits per voice, 0 = newest):
  - On allocating voice v, every other active voice whose rank is below v's old rank (or every other active voice, if v was free) increments, saturating at 2.
  - v's rank becomes 0.
- Divider:
  - Each active voice counts 0 .. P-1, where P = BASE_PERIOD[key] << DIV_SHIFT.
  - At count P-1, lfsr_en[v] pulses for one cycle and the count wraps to 0.
  - Allocation or steal resets the count to 0, so the first strobe comes P cycles after voice_active rises.
  - Inactive voices never strobe.
  - DIV_W must hold the maximum P; this is checked by an elaboration assertion.

Decomposition:
- Shared package lfsr_voice_pkg holds:
  - BASE_PERIOD table = {191, 170, 152, 143, 128, 114, 101, 96}, keys 0..7 = C4..C5 relative
  - NUM_VOICES = 3
  - key-index and rank typedefs
- One sub-module, voice_divider: a per-voice counter with load/clear and strobe output, instantiated 3 times.
- Allocation, ranks and pending logic stay in the top level.

Test Plan (DIV_SHIFT = 0):
- Reset then press key 0 at t → at t+1, voice_active = 001 and voice_key[2:0] = 0; lfsr_en[0] pulses at t+192, then every 191 cycles; lfsr_en[2:1] stay 0.
- Press keys 2, 5 and 7 in the same cycle → over 3 cycles voices 0, 1, 2 get keys 2, 5, 7 respectively; steal stays 0.
- With 3 voices busy (keys 2, 5, 7 allocated in that order), press key 4 → voice 0 (rank 2) gets key 4 and steal pulses once. Then press key 1 → voice 1 is stolen.
- Release key 5 while it is held, then press key 3 → voice 1 is freed, then reallocated to key 3 with no steal; an unknown release for key 6 changes nothing.
- Press and release key 6 in the same cycle with a voice free → key 6 ends allocated two cycles later.
- Assert reset mid-tone with 3 voices active → next cycle all outputs are 0 and no lfsr_en strobe follows; events pending before reset are not serviced.
